mux_select_sequencer: RTL and testbench
=======================================

// Module: mux_select_sequencer
// PURPOSE
//  Upstream control stage for the 3-input 8-bit selector mux. Arbitrates round-robin
//  among three requesting sources (channels 0/1/2 -> mux inputs in1/in2/in3) and drives
//  the mux 2-bit selector. Each granted source holds the mux for DWELL cycles, then gets
//  a one-cycle ack. When no source is granted, the selector parks at 2'b11 with sel_valid low.
// PARAMETERS
//  DWELL     4      cycles a grant holds the mux; legal range 1..255
//  CNT_W     8      dwell counter width; must satisfy 2**CNT_W > DWELL
//  IDLE_SEL  2'b11  selector value driven while idle
// PORTS
//  clock      in   1  single clock; all state changes on the rising edge
//  reset      in   1  synchronous, active-high
//  req        in   3  per-channel request; req[i] held high until ack[i] is seen
//  selector   out  2  to mux selector: 2'b00/01/10 = ch0/1/2; IDLE_SEL when idle
//  sel_valid  out  1  high while a grant is active (selector is 00/01/10)
//  grant      out  3  one-hot active channel; 3'b000 when idle
//  ack        out  3  one-cycle pulse on the last dwell cycle of a completed grant
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, selector=IDLE_SEL, sel_valid=0, grant=0, ack=0,
//   count=0, last=2 so ch0 has first priority. Reset overrides any grant mid-dwell; no ack.
//  All outputs are registered.
//  FSM states: IDLE, HOLD.
//  IDLE:
//   - If req==0, stay in IDLE.
//   - Otherwise pick the first set req[] searching from last+1 (mod 3) upward.
//   - Next edge: HOLD, grant=onehot(ch), selector=ch, sel_valid=1, count=DWELL-1, last=ch.
//   - Latency: req sampled high -> selector valid 1 cycle later.
//  HOLD:
//   - Each cycle: if req[ch]==1 and count!=0, count decrements.
//   - Terminal cycle is count==0: ack[ch]=1 for exactly this cycle, and selector stays
//     valid. Next edge -> IDLE (selector=IDLE_SEL, sel_valid=0, grant=0, ack=0).
//   - Abort: req[ch] sampled low with count!=0 -> next edge IDLE, no ack; last stays ch.
//   - Requests on other channels never pre-empt a grant.
//  Gap: at least one IDLE cycle between consecutive grants (selector=IDLE_SEL), so
//   back-to-back grant cadence is DWELL+1 cycles.
//  Requester protocol: clear req[i] on the edge that ends the ack[i] cycle. An ack
//   requires req[ch] high on the terminal cycle.
//  Fairness: with all three requesting continuously, grant order is 0,1,2,0,1,2...
//  DWELL=1: HOLD lasts one cycle, and ack is asserted in that cycle.
//  Invariants: grant is one-hot or zero; ack is a subset of grant; at most one ack bit is
//   high; sel_valid == (grant!=0).
// TESTING
//  1 reset high 2 cycles, req=000 -> selector=11, sel_valid=0, grant=000, ack=000.
//  2 req=001 held, DWELL=4, in1=5 at mux -> selector=00 for 4 cycles, mux out=5,
//    ack[0] on 4th cycle, then 1 idle cycle with selector=11.
//  3 req=111 held continuously (requesters re-raise after idle) -> selector sequence
//    00x4,11,01x4,11,10x4,11,00...; mux out 5,10,15.
//  4 req=010 drops after 2 grant cycles -> selector returns to 11 next edge, ack stays 000;
//    a following req=011 grants ch0 (round-robin after ch1).
//  5 reset asserted mid-HOLD (count=2) -> next edge selector=11, grant=000, no ack;
//    with req=110 afterwards, the first grant is ch1.
//  6 DWELL=1 build, req=100 -> selector=10 for 1 cycle with ack=100 in the same cycle.

Source files
------------

// File: rtl/mux_select_sequencer_if.sv
// Request/selector bundle between the three requesters, the sequencer and the 3:1 mux.
// Latency: none (wires only).
// Backpressure: requesters hold req[i] until ack[i]; there is no other flow control.
interface mux_select_sequencer_if;
  logic [2:0] req;        // per-channel request, held until its ack
  logic [1:0] selector;   // mux select: 00/01/10 = ch0/1/2, idle code otherwise
  logic       sel_valid;  // selector currently carries a granted channel
  logic [2:0] grant;      // one-hot owner of the mux, zero when idle
  logic [2:0] ack;        // one-cycle pulse on the final dwell cycle

  // Sequencer side: drives the mux selector and the grant/ack feedback.
  modport master (input req, output selector, sel_valid, grant, ack);
  // Requester/mux side.
  modport slave (output req, input selector, sel_valid, grant, ack);
endinterface

// File: rtl/mux_select_sequencer.sv
// Round-robin sequencer granting the 3:1 mux to one of three requesters for DWELL cycles.
// Latency: req sampled high -> registered selector/grant valid on the next edge; ack on the DWELL-th grant cycle.
// Backpressure: a grant holds until its dwell ends or its req drops; other requests wait, with one idle cycle between grants.
module mux_select_sequencer #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter logic [1:0]  IDLE_SEL = 2'b11
) (
  input logic              clock,
  input logic              reset,
  mux_select_sequencer_if.master bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       ch_q, ch_d;
  logic [1:0]       selector_q, selector_d;
  logic             sel_valid_q, sel_valid_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       ack_q, ack_d;

  logic [1:0]       ord0, ord1, ord2;
  logic [1:0]       pick;
  logic             pick_vld;

  // Round-robin search order starts just after the last granted channel.
  always_comb begin
    ord0     = 2'd0;
    ord1     = 2'd1;
    ord2     = 2'd2;
    pick     = 2'd0;
    pick_vld = 1'b0;
    case (last_q)
      2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    if (bus.req[ord0]) begin
      pick     = ord0;
      pick_vld = 1'b1;
    end else if (bus.req[ord1]) begin
      pick     = ord1;
      pick_vld = 1'b1;
    end else if (bus.req[ord2]) begin
      pick     = ord2;
      pick_vld = 1'b1;
    end
  end

  // Next-state and next-output logic; ack is registered, so it is raised one edge
  // ahead, when the dwell counter is about to reach zero.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_d      = last_q;
    ch_d        = ch_q;
    selector_d  = selector_q;
    sel_valid_d = sel_valid_q;
    grant_d     = grant_q;
    ack_d       = 3'b000;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = HOLD;
          ch_d        = pick;
          last_d      = pick;
          count_d     = DWELL_M1;
          selector_d  = pick;
          sel_valid_d = 1'b1;
          grant_d     = 3'b001 << pick;
          if (DWELL_M1 == '0) ack_d = 3'b001 << pick;
        end
      end
      HOLD: begin
        // Terminal cycle or aborted request: release the mux; last keeps ch.
        if (count_q == '0 || !bus.req[ch_q]) begin
          state_d     = IDLE;
          count_d     = '0;
          selector_d  = IDLE_SEL;
          sel_valid_d = 1'b0;
          grant_d     = 3'b000;
        end else begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) ack_d = grant_q;
        end
      end
      default: begin
        state_d     = IDLE;
        count_d     = '0;
        selector_d  = IDLE_SEL;
        sel_valid_d = 1'b0;
        grant_d     = 3'b000;
      end
    endcase
  end

  // State and output registers; reset parks the mux and gives ch0 first priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      last_q      <= 2'd2;
      ch_q        <= 2'd0;
      selector_q  <= IDLE_SEL;
      sel_valid_q <= 1'b0;
      grant_q     <= 3'b000;
      ack_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      ch_q        <= ch_d;
      selector_q  <= selector_d;
      sel_valid_q <= sel_valid_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.selector  = selector_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: DWELL=4 and DWELL=1 builds side by side.
// Latency: n/a.
// Backpressure: requesters clear req on the ack cycle, randomly raise/withdraw otherwise.
module tb_mux_select_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mux_select_sequencer_if bus4();
  mux_select_sequencer_if bus1();

  mux_select_sequencer #(.DWELL(4), .CNT_W(8), .IDLE_SEL(2'b11)) u_dut4 (
    .clock(clock), .reset(reset), .bus(bus4)
  );
  mux_select_sequencer #(.DWELL(1), .CNT_W(8), .IDLE_SEL(2'b11)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  int tests = 0;
  int fails = 0;

  // Reference: owner (-1 = nobody), cycles served so far in this grant, last owner.
  int m_owner[2]  = '{-1, -1};
  int m_served[2] = '{0, 0};
  int m_last[2]   = '{2, 2};
  int m_dwell[2]  = '{4, 1};

  logic [2:0] mr;
  int         mc;
  logic [2:0] eg, ea;
  logic [1:0] es;
  logic       ev;
  logic [2:0] rq, ak;

  int exp_sel2[5] = '{0, 0, 0, 0, 3};
  int exp_ack2[5] = '{0, 0, 0, 1, 0};
  int exp_sel3[15] = '{0, 0, 0, 0, 3, 1, 1, 1, 1, 3, 2, 2, 2, 2, 3};

  function automatic logic [2:0] req_of(input int k);
    return (k == 0) ? bus4.req : bus1.req;
  endfunction
  function automatic logic [1:0] sel_of(input int k);
    return (k == 0) ? bus4.selector : bus1.selector;
  endfunction
  function automatic logic vld_of(input int k);
    return (k == 0) ? bus4.sel_valid : bus1.sel_valid;
  endfunction
  function automatic logic [2:0] grant_of(input int k);
    return (k == 0) ? bus4.grant : bus1.grant;
  endfunction
  function automatic logic [2:0] ack_of(input int k);
    return (k == 0) ? bus4.ack : bus1.ack;
  endfunction

  function automatic int mux_out(input logic [1:0] s);
    case (s)
      2'd0: return 5;
      2'd1: return 10;
      2'd2: return 15;
      default: return 0;
    endcase
  endfunction

  task automatic set_req(input int k, input logic [2:0] v);
    if (k == 0) bus4.req = v;
    else bus1.req = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge clock);
  endtask

  // Reference update on each rising edge from the sampled reset/req.
  initial forever begin
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      mr = req_of(k);
      if (reset) begin
        m_owner[k]  = -1;
        m_served[k] = 0;
        m_last[k]   = 2;
      end else if (m_owner[k] < 0) begin
        if (mr != 3'b000) begin
          for (int j = 1; j <= 3; j++) begin
            mc = (m_last[k] + j) % 3;
            if (mr[mc] && m_owner[k] < 0) m_owner[k] = mc;
          end
          m_served[k] = 1;
          m_last[k]   = m_owner[k];
        end
      end else if (m_served[k] == m_dwell[k] || !mr[m_owner[k]]) begin
        m_owner[k]  = -1;
        m_served[k] = 0;
      end else begin
        m_served[k]++;
      end
    end
  end

  // Every-cycle comparison of both builds against the reference.
  initial forever begin
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      if (m_owner[k] >= 0) begin
        eg = 3'(1 << m_owner[k]);
        es = 2'(m_owner[k]);
        ev = 1'b1;
        ea = (m_served[k] == m_dwell[k]) ? eg : 3'b000;
      end else begin
        eg = 3'b000;
        es = 2'b11;
        ev = 1'b0;
        ea = 3'b000;
      end
      chk($sformatf("model_selector[%0d]", k), 32'(sel_of(k)), 32'(es));
      chk($sformatf("model_sel_valid[%0d]", k), 32'(vld_of(k)), 32'(ev));
      chk($sformatf("model_grant[%0d]", k), 32'(grant_of(k)), 32'(eg));
      chk($sformatf("model_ack[%0d]", k), 32'(ack_of(k)), 32'(ea));
    end
  end

  initial begin
    set_req(0, 3'b000);
    set_req(1, 3'b000);

    // Reset state after two reset cycles.
    repeat (2) @(negedge clock);
    chk("reset_selector", 32'(bus4.selector), 32'd3);
    chk("reset_sel_valid", 32'(bus4.sel_valid), 32'd0);
    chk("reset_grant", 32'(bus4.grant), 32'd0);
    chk("reset_ack", 32'(bus4.ack), 32'd0);
    chk("reset_ack_d1", 32'(bus1.ack), 32'd0);
    reset = 1'b0;

    // Single requester on ch0: four dwell cycles, ack on the fourth, then idle.
    set_req(0, 3'b001);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t2_selector_c%0d", c), 32'(bus4.selector), 32'(exp_sel2[c]));
      chk($sformatf("t2_ack_c%0d", c), 32'(bus4.ack), 32'(exp_ack2[c]));
      if (c == 0) chk("t2_mux_out", 32'(mux_out(bus4.selector)), 32'd5);
      if (bus4.ack[0]) set_req(0, 3'b000);
    end

    // Abort after two grant cycles, then round-robin continues after ch1.
    set_req(0, 3'b010);
    step();
    chk("t4_grant_c0", 32'(bus4.grant), 32'd2);
    step();
    chk("t4_grant_c1", 32'(bus4.grant), 32'd2);
    set_req(0, 3'b000);
    step();
    chk("t4_abort_selector", 32'(bus4.selector), 32'd3);
    chk("t4_abort_ack", 32'(bus4.ack), 32'd0);
    chk("t4_model_last", 32'(m_last[0]), 32'd1);
    set_req(0, 3'b011);
    step();
    chk("t4_rr_grant", 32'(bus4.grant), 32'd1);
    set_req(0, 3'b000);
    step();
    step();

    // Reset mid-dwell drops the grant without ack and restores ch0-first priority.
    set_req(0, 3'b010);
    step();
    step();
    reset = 1'b1;
    step();
    chk("t5_reset_selector", 32'(bus4.selector), 32'd3);
    chk("t5_reset_grant", 32'(bus4.grant), 32'd0);
    chk("t5_reset_ack", 32'(bus4.ack), 32'd0);
    reset = 1'b0;
    set_req(0, 3'b110);
    step();
    chk("t5_first_grant", 32'(bus4.grant), 32'd2);
    chk("t5_model_owner", 32'(m_owner[0]), 32'd1);
    set_req(0, 3'b000);
    step();
    step();

    // All three requesting continuously: 0,1,2 with one idle cycle between grants.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 3'b111);
    for (int c = 0; c < 15; c++) begin
      step();
      chk($sformatf("t3_selector_c%0d", c), 32'(bus4.selector), 32'(exp_sel3[c]));
      if (c == 0) chk("t3_mux_ch0", 32'(mux_out(bus4.selector)), 32'd5);
      if (c == 5) chk("t3_mux_ch1", 32'(mux_out(bus4.selector)), 32'd10);
      if (c == 10) chk("t3_mux_ch2", 32'(mux_out(bus4.selector)), 32'd15);
    end
    set_req(0, 3'b000);
    step();
    step();

    // DWELL=1: one-cycle grant with ack in the same cycle.
    set_req(1, 3'b100);
    step();
    chk("t6_selector", 32'(bus1.selector), 32'd2);
    chk("t6_ack", 32'(bus1.ack), 32'd4);
    chk("t6_grant", 32'(bus1.grant), 32'd4);
    set_req(1, 3'b000);
    step();
    chk("t6_idle_selector", 32'(bus1.selector), 32'd3);
    chk("t6_idle_ack", 32'(bus1.ack), 32'd0);

    // Random requesters on both builds with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        rq = req_of(k);
        ak = ack_of(k);
        for (int i = 0; i < 3; i++) begin
          if (rq[i]) begin
            if (ak[i] || $urandom_range(0, 15) == 0) rq[i] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            rq[i] = 1'b1;
          end
        end
        set_req(k, rq);
      end
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
